// File: rtl/motor_ctrl_pkg.sv
// Shared definitions for the motor current and speed control loops:
// loop FSM encoding, default gain shifts and the output saturating clamp.
package motor_ctrl_pkg;

    typedef enum logic [1:0] {
        PI_IDLE,
        PI_WAIT,
        PI_CALC,
        PI_APPLY
    } pi_state_t;

    localparam int unsigned DEF_KP_SHIFT = 4;
    localparam int unsigned DEF_KI_SHIFT = 8;

    // Clamp a signed value into [0, 2^outW-1]; hi/lo report which bound was hit.
    function automatic logic [63:0] clampUnsigned(
        input  logic signed [63:0] val,
        input  int unsigned        outW,
        output logic               hi,
        output logic               lo
    );
        logic signed [63:0] maxVal;
        logic        [63:0] result;
        maxVal = (64'sd1 <<< outW) - 64'sd1;
        hi     = 1'b0;
        lo     = 1'b0;
        if (val > maxVal) begin
            hi     = 1'b1;
            result = maxVal;
        end else if (val < 64'sd0) begin
            lo     = 1'b1;
            result = '0;
        end else begin
            result = val;
        end
        return result;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running modulo-DIV counter producing a one-cycle tick on its last count.
module tick_divider #(
    parameter int unsigned DIV = 256
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] tickCnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            tickCnt <= '0;
        end else if (tickCnt == LAST) begin
            tickCnt <= '0;
        end else begin
            tickCnt <= tickCnt + CNT_W'(1);
        end
    end

    assign tick = (tickCnt == LAST);

endmodule

// File: rtl/current_pi_ctrl.sv
// PI motor current regulator: ticked error evaluation, clamped duty output,
// integrator anti-windup, stale-sample detection and zero-assist shutdown.
module current_pi_ctrl
    import motor_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W   = 12,
    parameter int unsigned OUT_W    = 8,
    parameter int unsigned DIV      = 256,
    parameter int unsigned KP_SHIFT = DEF_KP_SHIFT,
    parameter int unsigned KI_SHIFT = DEF_KI_SHIFT,
    parameter int unsigned ACC_W    = 24
) (
    input  logic              c20k,
    input  logic              rst,
    input  logic              enable,
    input  logic [DATA_W-1:0] setpoint,
    input  logic [DATA_W-1:0] feedback,
    input  logic              sample_valid,
    output logic [OUT_W-1:0]  duty,
    output logic              update,
    output logic              sat_hi,
    output logic              sat_lo,
    output logic              stale,
    output logic [DATA_W:0]   error
);

    pi_state_t state, stateNext;

    logic tick;
    logic hasSample;
    logic calcEn;
    logic applyEn;
    logic staleHit;
    logic tickTaken;

    logic [DATA_W-1:0] fbQ;
    logic              fresh;
    logic              zeroQ;

    logic signed [DATA_W:0]  errC;
    logic signed [DATA_W:0]  errQ;
    logic signed [ACC_W-1:0] integ;
    logic signed [ACC_W-1:0] integNextC;
    logic signed [ACC_W-1:0] integNextQ;
    logic signed [ACC_W:0]   integSum;
    logic signed [ACC_W:0]   sumC;

    logic [OUT_W-1:0] dutyC;
    logic             hiC;
    logic             loC;
    logic             holdInteg;

    tick_divider #(.DIV(DIV)) uTickDiv (
        .clk  (c20k),
        .rst  (rst),
        .tick (tick)
    );

    always_ff @(posedge c20k) begin
        if (rst) begin
            state <= PI_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // A strobe landing on the tick cycle counts as fresh for that tick.
    assign hasSample = fresh | sample_valid;

    always_comb begin
        stateNext = state;
        calcEn    = 1'b0;
        applyEn   = 1'b0;
        staleHit  = 1'b0;
        tickTaken = 1'b0;
        if (!enable) begin
            stateNext = PI_IDLE;
        end else begin
            case (state)
                PI_IDLE: stateNext = PI_WAIT;
                PI_WAIT: begin
                    if (tick) begin
                        if (hasSample) begin
                            stateNext = PI_CALC;
                            tickTaken = 1'b1;
                        end else begin
                            staleHit = 1'b1;
                        end
                    end
                end
                PI_CALC: begin
                    stateNext = PI_APPLY;
                    calcEn    = 1'b1;
                end
                PI_APPLY: begin
                    stateNext = PI_WAIT;
                    applyEn   = 1'b1;
                end
                default: stateNext = PI_IDLE;
            endcase
        end
    end

    always_comb begin
        errC     = $signed({1'b0, setpoint}) - $signed({1'b0, fbQ});
        integSum = (ACC_W+1)'(integ) + (ACC_W+1)'(errC);
        if (integSum[ACC_W] != integSum[ACC_W-1]) begin
            integNextC = integSum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                         : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            integNextC = integSum[ACC_W-1:0];
        end
    end

    always_comb begin
        hiC       = 1'b0;
        loC       = 1'b0;
        sumC      = (ACC_W+1)'(errQ >>> KP_SHIFT) + (ACC_W+1)'(integNextQ >>> KI_SHIFT);
        dutyC     = OUT_W'(clampUnsigned(64'(sumC), OUT_W, hiC, loC));
        // Freeze the integrator only when the error drives deeper into the active clamp.
        holdInteg = (hiC && !errQ[DATA_W] && (errQ != '0)) || (loC && errQ[DATA_W]);
    end

    always_ff @(posedge c20k) begin
        if (rst) begin
            fbQ        <= '0;
            fresh      <= 1'b0;
            zeroQ      <= 1'b0;
            errQ       <= '0;
            integ      <= '0;
            integNextQ <= '0;
            duty       <= '0;
            update     <= 1'b0;
            sat_hi     <= 1'b0;
            sat_lo     <= 1'b0;
            stale      <= 1'b0;
            error      <= '0;
        end else begin
            update <= 1'b0;
            if (sample_valid) begin
                fbQ   <= feedback;
                fresh <= 1'b1;
            end
            if (tick) begin
                fresh <= 1'b0;
            end
            if (staleHit) begin
                stale <= 1'b1;
            end
            if (tickTaken) begin
                stale <= 1'b0;
            end
            if (calcEn) begin
                errQ       <= errC;
                integNextQ <= integNextC;
                zeroQ      <= (setpoint == '0);
            end
            if (!enable) begin
                duty  <= '0;
                integ <= '0;
            end else if (applyEn) begin
                update <= 1'b1;
                error  <= errQ;
                if (zeroQ) begin
                    duty   <= '0;
                    integ  <= '0;
                    sat_hi <= 1'b0;
                    sat_lo <= 1'b0;
                end else begin
                    duty   <= dutyC;
                    sat_hi <= hiC;
                    sat_lo <= loC;
                    if (!holdInteg) begin
                        integ <= integNextQ;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_current_pi_ctrl.sv
// Self-checking bench for current_pi_ctrl: directed vector table, hand-written
// reset/enable/strobe corner sequences and randomized periods against a reference model.
module tb_current_pi_ctrl;

    localparam int DIV     = 16;
    localparam int ACC_MAX = (1 << 23) - 1;
    localparam int ACC_MIN = -(1 << 23);

    logic        c20k = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        sample_valid = 1'b0;
    logic [11:0] setpoint = '0;
    logic [11:0] feedback = '0;
    logic [7:0]  duty;
    logic        update;
    logic        sat_hi;
    logic        sat_lo;
    logic        stale;
    logic [12:0] error;

    always #5 c20k = ~c20k;

    current_pi_ctrl #(
        .DATA_W   (12),
        .OUT_W    (8),
        .DIV      (DIV),
        .KP_SHIFT (4),
        .KI_SHIFT (8),
        .ACC_W    (24)
    ) dut (
        .c20k         (c20k),
        .rst          (rst),
        .enable       (enable),
        .setpoint     (setpoint),
        .feedback     (feedback),
        .sample_valid (sample_valid),
        .duty         (duty),
        .update       (update),
        .sat_hi       (sat_hi),
        .sat_lo       (sat_lo),
        .stale        (stale),
        .error        (error)
    );

    typedef struct {
        int sp;
        int fb;
        int strobeAt;
        int expUpd;
        int expDuty;
        int expErr;
        int expHi;
        int expLo;
        int expStale;
    } vec_t;

    vec_t vecs[11];

    int nChecks = 0;
    int nFail   = 0;
    int cyc     = 0;

    // Reference model state: one update per fresh period, plain integer arithmetic.
    int mInteg, mDuty, mErr, mHi, mLo, mStale;

    task automatic chk(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge c20k);
        #1;
        cyc = (cyc + 1) % DIV;
    endtask

    task automatic syncTo(input int c);
        while (cyc != c) step();
    endtask

    task automatic modelReset();
        mInteg = 0; mDuty = 0; mErr = 0; mHi = 0; mLo = 0; mStale = 0;
    endtask

    task automatic modelPeriod(input int sp, input int fb, input bit strobed, output int upd);
        int e, p, iN, s;
        if (!strobed) begin
            mStale = 1;
            upd    = 0;
            return;
        end
        mStale = 0;
        upd    = 1;
        e      = sp - fb;
        mErr   = e;
        if (sp == 0) begin
            mDuty = 0; mInteg = 0; mHi = 0; mLo = 0;
            return;
        end
        iN = mInteg + e;
        if (iN > ACC_MAX) iN = ACC_MAX;
        if (iN < ACC_MIN) iN = ACC_MIN;
        p = e >>> 4;
        s = p + (iN >>> 8);
        mHi = 0; mLo = 0;
        if (s > 255) begin
            mDuty = 255; mHi = 1;
        end else if (s < 0) begin
            mDuty = 0; mLo = 1;
        end else begin
            mDuty = s;
        end
        if (!((mHi == 1 && e > 0) || (mLo == 1 && e < 0))) mInteg = iN;
    endtask

    // One update period, entered and left at cyc 3 (after the previous CALC).
    task automatic doPeriod(input int sp, input int fb, input int strobeAt, output int updCnt);
        setpoint = 12'(sp);
        feedback = 12'(fb);
        updCnt   = 0;
        for (int k = 0; k < DIV; k++) begin
            sample_valid = (cyc == strobeAt);
            step();
            if (update) updCnt++;
        end
        sample_valid = 1'b0;
    endtask

    task automatic runModel(input string tag, input int sp, input int fb, input int strobeAt);
        int updCnt, mUpd;
        doPeriod(sp, fb, strobeAt, updCnt);
        modelPeriod(sp, fb, strobeAt >= 0, mUpd);
        chk({tag, "_upd"},   updCnt,        mUpd);
        chk({tag, "_duty"},  int'(duty),    mDuty);
        chk({tag, "_err"},   int'(error),   mErr & 'h1FFF);
        chk({tag, "_hi"},    int'(sat_hi),  mHi);
        chk({tag, "_lo"},    int'(sat_lo),  mLo);
        chk({tag, "_stale"}, int'(stale),   mStale);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1);
    end

    initial begin
        int updCnt, mUpd, cnt, left, sp, fb, sa;

        vecs[0]  = '{'h400, 'h000, 4,       1, 68,  'h0400, 0, 0, 0};
        vecs[1]  = '{'h400, 'h000, 4,       1, 72,  'h0400, 0, 0, 0};
        vecs[2]  = '{'h400, 'h000, -1,      0, 72,  'h0400, 0, 0, 1};
        vecs[3]  = '{'h400, 'h400, 4,       1, 8,   'h0000, 0, 0, 0};
        vecs[4]  = '{'h000, 'h100, 4,       1, 0,   'h1F00, 0, 0, 0};
        vecs[5]  = '{'h100, 'h200, 4,       1, 0,   'h1F00, 0, 1, 0};
        vecs[6]  = '{'h800, 'h800, 4,       1, 0,   'h0000, 0, 0, 0};
        vecs[7]  = '{'hFFF, 'h000, 4,       1, 255, 'h0FFF, 1, 0, 0};
        vecs[8]  = '{'hFFF, 'hFFF, 4,       1, 0,   'h0000, 0, 0, 0};
        vecs[9]  = '{'h010, 'h000, DIV - 1, 1, 1,   'h0010, 0, 0, 0};
        vecs[10] = '{'h010, 'h000, -1,      0, 1,   'h0010, 0, 0, 1};

        modelReset();
        rst    = 1'b1;
        enable = 1'b1;
        repeat (3) @(posedge c20k);
        #1;
        rst = 1'b0;
        cyc = 0;
        chk("rst_duty",   int'(duty),   0);
        chk("rst_update", int'(update), 0);
        chk("rst_hi",     int'(sat_hi), 0);
        chk("rst_lo",     int'(sat_lo), 0);
        chk("rst_stale",  int'(stale),  0);
        chk("rst_error",  int'(error),  0);
        syncTo(3);

        foreach (vecs[i]) begin
            doPeriod(vecs[i].sp, vecs[i].fb, vecs[i].strobeAt, updCnt);
            modelPeriod(vecs[i].sp, vecs[i].fb, vecs[i].strobeAt >= 0, mUpd);
            chk($sformatf("vec%0d_upd", i),   updCnt,        vecs[i].expUpd);
            chk($sformatf("vec%0d_duty", i),  int'(duty),    vecs[i].expDuty);
            chk($sformatf("vec%0d_err", i),   int'(error),   vecs[i].expErr);
            chk($sformatf("vec%0d_hi", i),    int'(sat_hi),  vecs[i].expHi);
            chk($sformatf("vec%0d_lo", i),    int'(sat_lo),  vecs[i].expLo);
            chk($sformatf("vec%0d_stale", i), int'(stale),   vecs[i].expStale);
        end

        // Reset landing on the CALC cycle aborts the update.
        runModel("pre_rst", 'h400, 'h000, 4);
        setpoint     = 12'h400;
        feedback     = 12'h000;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        syncTo(0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        cyc = 0;
        chk("calc_rst_duty",   int'(duty),   0);
        chk("calc_rst_update", int'(update), 0);
        chk("calc_rst_hi",     int'(sat_hi), 0);
        chk("calc_rst_lo",     int'(sat_lo), 0);
        chk("calc_rst_stale",  int'(stale),  0);
        chk("calc_rst_error",  int'(error),  0);
        cnt = 0;
        repeat (3) begin
            step();
            if (update) cnt++;
        end
        chk("calc_rst_noupd", cnt, 0);
        modelReset();
        syncTo(3);

        // Enable dropping in APPLY forces duty to zero without an update.
        runModel("pre_en", 'h400, 'h000, 5);
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        syncTo(1);
        enable = 1'b0;
        step();
        chk("apply_dis_duty",   int'(duty),   0);
        chk("apply_dis_update", int'(update), 0);
        cnt = 0;
        while (cyc != 3) begin
            step();
            if (update) cnt++;
        end
        chk("apply_dis_noupd", cnt, 0);
        enable = 1'b1;
        mDuty  = 0;
        mInteg = 0;
        mStale = 0;
        runModel("post_en", 'h400, 'h000, 4);

        // Strobe on the tick cycle is used, then the following period is stale.
        runModel("same_tick", 'h300, 'h100, DIV - 1);
        runModel("same_stale", 'h300, 'h200, -1);
        runModel("stale_clr", 'h300, 'h200, 6);

        // Long saturation, then release: duty must leave the high rail promptly.
        for (int i = 0; i < 20; i++) runModel("windup", 'hFFF, 'h000, 4);
        chk("windup_duty", int'(duty),   255);
        chk("windup_hi",   int'(sat_hi), 1);
        left = 0;
        runModel("release1", 'hFFF, 'hFFF, 4);
        if (duty != 8'd255) left = 1;
        runModel("release2", 'hFFF, 'hFFF, 4);
        if (duty != 8'd255) left = 1;
        chk("windup_release", left, 1);

        runModel("zero_sp", 'h000, 'h300, 4);
        runModel("neg_err", 'h200, 'h600, 4);

        for (int i = 0; i < 60; i++) begin
            sp = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(0, 4095));
            fb = int'($urandom_range(0, 4095));
            sa = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(3, DIV - 1));
            runModel($sformatf("rnd%0d", i), sp, fb, sa);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
